parking_gate_sequencer: RTL and testbench

// - Gate-side transmitter for the parking counter block. Turns raw entry/exit gate requests into its
//   car_entered/is_uni_car_entered and car_exited/is_uni_car_exited strobes; the counter commits on the

---
 rtl/parking_gate_if.sv | 52 +++++
 rtl/parking_gate_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_parking_gate_sequencer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/parking_gate_if.sv
// Gate-side bus of the parking gate sequencer: raw gate requests and space flags in, commit strobes and actuators out.
// The statistics counters exist only when PARKING_GATE_STATS_EN is defined.
interface parking_gate_if #(
  parameter int unsigned ENTRY_FIFO_DEPTH = 4
);
  localparam int unsigned LEVEL_W = $clog2(ENTRY_FIFO_DEPTH) + 1;

  logic               entry_req;
  logic               entry_is_uni;
  logic               exit_req;
  logic               exit_is_uni;
  logic               uni_is_vacated_space;
  logic               free_is_vacated_space;
  logic               car_entered;
  logic               is_uni_car_entered;
  logic               car_exited;
  logic               is_uni_car_exited;
  logic               barrier_in_open;
  logic               barrier_out_open;
  logic               entry_denied;
  logic               req_dropped;
  logic [LEVEL_W-1:0] entry_queue_level;
`ifdef PARKING_GATE_STATS_EN
  logic [15:0]        granted_count;
  logic [15:0]        denied_count;
  logic [15:0]        dropped_count;
`endif

  // Sequencer side
  modport master (
    input  entry_req, entry_is_uni, exit_req, exit_is_uni,
    input  uni_is_vacated_space, free_is_vacated_space,
    output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
    output barrier_in_open, barrier_out_open, entry_denied, req_dropped,
    output entry_queue_level
`ifdef PARKING_GATE_STATS_EN
    , output granted_count, denied_count, dropped_count
`endif
  );

  // Gate hardware / parking counter side
  modport slave (
    output entry_req, entry_is_uni, exit_req, exit_is_uni,
    output uni_is_vacated_space, free_is_vacated_space,
    input  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
    input  barrier_in_open, barrier_out_open, entry_denied, req_dropped,
    input  entry_queue_level
`ifdef PARKING_GATE_STATS_EN
    , input granted_count, denied_count, dropped_count
`endif
  );
endinterface

// File: rtl/parking_gate_sequencer.sv
// Turns raw entry/exit gate requests into commit strobes for the parking counter and drives the barriers.
// Optional saturating statistics counters are enabled by defining PARKING_GATE_STATS_EN.
module parking_gate_sequencer #(
  parameter int unsigned ENTRY_FIFO_DEPTH = 4,
  parameter int unsigned OPEN_CYCLES      = 3,
  parameter int unsigned PULSE_CYCLES     = 2,
  parameter int unsigned SETTLE_CYCLES    = 2
) (
  input  logic           clock,
  input  logic           reset,
  parking_gate_if.master bus
);
  localparam int unsigned PTR_W   = $clog2(ENTRY_FIFO_DEPTH);
  localparam int unsigned LEVEL_W = PTR_W + 1;
  localparam int unsigned MAX_OP  = (OPEN_CYCLES > PULSE_CYCLES) ? OPEN_CYCLES : PULSE_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_OP > SETTLE_CYCLES) ? MAX_OP : SETTLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0]   OPEN_LAST   = CNT_W'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0]   PULSE_LAST  = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] FULL_LEVEL  = LEVEL_W'(ENTRY_FIFO_DEPTH);

  typedef enum logic [2:0] {E_IDLE, E_CHECK, E_OPEN, E_PULSE, E_HOLD, E_SETTLE} entry_state_t;
  typedef enum logic [1:0] {X_IDLE, X_OPEN, X_PULSE, X_HOLD} exit_state_t;

  entry_state_t e_state_q, e_state_d;
  exit_state_t  x_state_q, x_state_d;
  logic [CNT_W-1:0] e_cnt_q, e_cnt_d, x_cnt_q, x_cnt_d;
  logic ent_uni_q, ent_uni_d, barrier_in_q, barrier_in_d, car_entered_q, car_entered_d;
  logic denied_q, denied_d, ext_uni_q, ext_uni_d, barrier_out_q, barrier_out_d;
  logic car_exited_q, car_exited_d, dropped_q, dropped_d;

  logic [ENTRY_FIFO_DEPTH-1:0] fifo_q;
  logic [PTR_W-1:0]            rd_ptr_q, wr_ptr_q;
  logic [LEVEL_W-1:0]          level_q;
  logic                        pop, push, fifo_drop, exit_drop, space_ok;

  // A full FIFO still accepts a request when the head leaves on the same edge
  assign push      = bus.entry_req && ((level_q != FULL_LEVEL) || pop);
  assign fifo_drop = bus.entry_req && !push;
  assign exit_drop = bus.exit_req && (x_state_q != X_IDLE);
  assign dropped_d = fifo_drop || exit_drop;
  assign space_ok  = ent_uni_q ? bus.uni_is_vacated_space : bus.free_is_vacated_space;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fifo_q    <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      level_q   <= '0;
      dropped_q <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= bus.entry_is_uni;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q   <= level_q + LEVEL_W'(push) - LEVEL_W'(pop);
      dropped_q <= dropped_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      e_state_q     <= E_IDLE;
      e_cnt_q       <= '0;
      ent_uni_q     <= 1'b0;
      barrier_in_q  <= 1'b0;
      car_entered_q <= 1'b0;
      denied_q      <= 1'b0;
    end else begin
      e_state_q     <= e_state_d;
      e_cnt_q       <= e_cnt_d;
      ent_uni_q     <= ent_uni_d;
      barrier_in_q  <= barrier_in_d;
      car_entered_q <= car_entered_d;
      denied_q      <= denied_d;
    end
  end

  always_comb begin
    e_state_d     = e_state_q;
    e_cnt_d       = e_cnt_q;
    ent_uni_d     = ent_uni_q;
    barrier_in_d  = 1'b0;
    car_entered_d = 1'b0;
    denied_d      = 1'b0;
    pop           = 1'b0;
    unique case (e_state_q)
      E_IDLE: begin
        if (level_q != '0) begin
          pop       = 1'b1;
          ent_uni_d = fifo_q[rd_ptr_q];
          e_state_d = E_CHECK;
        end
      end
      E_CHECK: begin
        e_cnt_d = '0;
        if (space_ok) begin
          e_state_d    = E_OPEN;
          barrier_in_d = 1'b1;
        end else begin
          e_state_d = E_SETTLE;
          denied_d  = 1'b1;
        end
      end
      E_OPEN: begin
        barrier_in_d = 1'b1;
        if (e_cnt_q == OPEN_LAST) begin
          e_state_d     = E_PULSE;
          e_cnt_d       = '0;
          car_entered_d = 1'b1;
        end else begin
          e_cnt_d = e_cnt_q + CNT_W'(1);
        end
      end
      E_PULSE: begin
        if (e_cnt_q == PULSE_LAST) begin
          e_state_d = E_HOLD;
        end else begin
          barrier_in_d  = 1'b1;
          car_entered_d = 1'b1;
          e_cnt_d       = e_cnt_q + CNT_W'(1);
        end
      end
      E_HOLD: begin
        e_state_d = E_SETTLE;
        e_cnt_d   = '0;
      end
      E_SETTLE: begin
        if (e_cnt_q == SETTLE_LAST) e_state_d = E_IDLE;
        else                        e_cnt_d   = e_cnt_q + CNT_W'(1);
      end
      default: e_state_d = E_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_state_q     <= X_IDLE;
      x_cnt_q       <= '0;
      ext_uni_q     <= 1'b0;
      barrier_out_q <= 1'b0;
      car_exited_q  <= 1'b0;
    end else begin
      x_state_q     <= x_state_d;
      x_cnt_q       <= x_cnt_d;
      ext_uni_q     <= ext_uni_d;
      barrier_out_q <= barrier_out_d;
      car_exited_q  <= car_exited_d;
    end
  end

  always_comb begin
    x_state_d     = x_state_q;
    x_cnt_d       = x_cnt_q;
    ext_uni_d     = ext_uni_q;
    barrier_out_d = 1'b0;
    car_exited_d  = 1'b0;
    unique case (x_state_q)
      X_IDLE: begin
        if (bus.exit_req) begin
          ext_uni_d     = bus.exit_is_uni;
          x_state_d     = X_OPEN;
          x_cnt_d       = '0;
          barrier_out_d = 1'b1;
        end
      end
      X_OPEN: begin
        barrier_out_d = 1'b1;
        if (x_cnt_q == OPEN_LAST) begin
          x_state_d    = X_PULSE;
          x_cnt_d      = '0;
          car_exited_d = 1'b1;
        end else begin
          x_cnt_d = x_cnt_q + CNT_W'(1);
        end
      end
      X_PULSE: begin
        if (x_cnt_q == PULSE_LAST) begin
          x_state_d = X_HOLD;
        end else begin
          barrier_out_d = 1'b1;
          car_exited_d  = 1'b1;
          x_cnt_d       = x_cnt_q + CNT_W'(1);
        end
      end
      X_HOLD:  x_state_d = X_IDLE;
      default: x_state_d = X_IDLE;
    endcase
  end

  assign bus.car_entered        = car_entered_q;
  assign bus.is_uni_car_entered = ent_uni_q;
  assign bus.car_exited         = car_exited_q;
  assign bus.is_uni_car_exited  = ext_uni_q;
  assign bus.barrier_in_open    = barrier_in_q;
  assign bus.barrier_out_open   = barrier_out_q;
  assign bus.entry_denied       = denied_q;
  assign bus.req_dropped        = dropped_q;
  assign bus.entry_queue_level  = level_q;

`ifdef PARKING_GATE_STATS_EN
  logic [15:0] granted_q, denied_cnt_q, dropped_cnt_q;
  logic        granted_evt;

  assign granted_evt = (e_state_q == E_PULSE) && (e_state_d == E_HOLD);

  // Saturating event counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      granted_q     <= '0;
      denied_cnt_q  <= '0;
      dropped_cnt_q <= '0;
    end else begin
      if (granted_evt && (granted_q != 16'hFFFF))     granted_q     <= granted_q + 16'd1;
      if (denied_d && (denied_cnt_q != 16'hFFFF))     denied_cnt_q  <= denied_cnt_q + 16'd1;
      if (dropped_d && (dropped_cnt_q != 16'hFFFF))   dropped_cnt_q <= dropped_cnt_q + 16'd1;
    end
  end

  assign bus.granted_count = granted_q;
  assign bus.denied_count  = denied_cnt_q;
  assign bus.dropped_count = dropped_cnt_q;
`endif
endmodule

// File: tb/tb_parking_gate_sequencer.sv
// Self-checking bench for parking_gate_sequencer: waveform checks, a vector table and a commit scoreboard.
module tb_parking_gate_sequencer;
  logic clock = 1'b0;
  logic reset;

  parking_gate_if #(.ENTRY_FIFO_DEPTH(4)) bus ();

  parking_gate_sequencer #(
    .ENTRY_FIFO_DEPTH(4),
    .OPEN_CYCLES     (3),
    .PULSE_CYCLES    (2),
    .SETTLE_CYCLES   (2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic granted;
    logic is_uni;
  } entry_exp_t;

  typedef struct {
    logic is_uni;
    logic uni_flag;
    logic free_flag;
    logic exp_granted;
  } vec_t;

  entry_exp_t entry_q[$];
  logic       exit_q[$];
  int         rise_q[$];
  vec_t       vecs[6];
  entry_exp_t ee;
  logic       xe;

  int   n_checks = 0;
  int   n_fail = 0;
  int   ent_commits = 0;
  int   ext_commits = 0;
  int   drops = 0;
  int   denials = 0;
  int   cyc = 0;
  logic prev_ce = 1'b0;
  logic prev_cx = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({bus.car_entered, bus.is_uni_car_entered, bus.car_exited, bus.is_uni_car_exited,
                bus.barrier_in_open, bus.barrier_out_open, bus.entry_denied, bus.req_dropped,
                bus.entry_queue_level});
  endfunction

  // Scoreboard: commits are the falling edges of the strobes
  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      prev_ce = 1'b0;
      prev_cx = 1'b0;
    end else begin
      if (bus.car_entered && !prev_ce) rise_q.push_back(cyc);
      if (!bus.car_entered && prev_ce) begin
        ent_commits++;
        chk("entry_commit_expected", 32'(entry_q.size() != 0), 32'd1);
        if (entry_q.size() != 0) begin
          ee = entry_q.pop_front();
          chk("entry_commit_granted", 32'(ee.granted), 32'd1);
          chk("entry_commit_class", 32'(bus.is_uni_car_entered), 32'(ee.is_uni));
        end
      end
      if (bus.entry_denied) begin
        denials++;
        chk("entry_deny_expected", 32'(entry_q.size() != 0), 32'd1);
        if (entry_q.size() != 0) begin
          ee = entry_q.pop_front();
          chk("entry_deny_granted", 32'(ee.granted), 32'd0);
        end
      end
      if (!bus.car_exited && prev_cx) begin
        ext_commits++;
        chk("exit_commit_expected", 32'(exit_q.size() != 0), 32'd1);
        if (exit_q.size() != 0) begin
          xe = exit_q.pop_front();
          chk("exit_commit_class", 32'(bus.is_uni_car_exited), 32'(xe));
        end
      end
      if (bus.req_dropped) drops++;
      prev_ce = bus.car_entered;
      prev_cx = bus.car_exited;
    end
  end

  initial begin
    logic [15:0] ce_bits, bi_bits, un_bits, dn_bits;
    int c0, d0, x0, n0, min_gap, waited;

    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0};

    reset = 1'b1;
    bus.entry_req = 1'b0;
    bus.entry_is_uni = 1'b0;
    bus.exit_req = 1'b0;
    bus.exit_is_uni = 1'b0;
    bus.uni_is_vacated_space = 1'b1;
    bus.free_is_vacated_space = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_outputs", all_outs(), 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_outputs", all_outs(), 32'd0);

    // Single uni entry: exact strobe and barrier waveform
    c0 = ent_commits;
    bus.entry_req = 1'b1;
    bus.entry_is_uni = 1'b1;
    entry_q.push_back('{granted: 1'b1, is_uni: 1'b1});
    tick();
    bus.entry_req = 1'b0;
    ce_bits = '0; bi_bits = '0; un_bits = '0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      ce_bits[k] = bus.car_entered;
      bi_bits[k] = bus.barrier_in_open;
      un_bits[k] = bus.is_uni_car_entered;
    end
    chk("t1_car_entered_wave", 32'(ce_bits), 32'h0060);
    chk("t1_barrier_in_wave", 32'(bi_bits), 32'h007C);
    chk("t1_uni_class_wave", 32'(un_bits & 16'h00FE), 32'h00FE);
    chk("t1_commit_count", ent_commits - c0, 1);

    // Free entry with no free space: denial, no barrier, no strobe
    c0 = ent_commits;
    bus.free_is_vacated_space = 1'b0;
    bus.entry_req = 1'b1;
    bus.entry_is_uni = 1'b0;
    entry_q.push_back('{granted: 1'b0, is_uni: 1'b0});
    tick();
    bus.entry_req = 1'b0;
    ce_bits = '0; bi_bits = '0; dn_bits = '0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      ce_bits[k] = bus.car_entered;
      bi_bits[k] = bus.barrier_in_open;
      dn_bits[k] = bus.entry_denied;
    end
    chk("t2_denied_wave", 32'(dn_bits), 32'h0004);
    chk("t2_no_barrier", 32'(bi_bits), 32'h0000);
    chk("t2_no_strobe", 32'(ce_bits), 32'h0000);
    chk("t2_commit_count", ent_commits - c0, 0);

    // Vector table: class x space flags
    for (int v = 0; v < 6; v++) begin
      c0 = ent_commits;
      n0 = denials;
      bus.uni_is_vacated_space = vecs[v].uni_flag;
      bus.free_is_vacated_space = vecs[v].free_flag;
      bus.entry_req = 1'b1;
      bus.entry_is_uni = vecs[v].is_uni;
      entry_q.push_back('{granted: vecs[v].exp_granted, is_uni: vecs[v].is_uni});
      tick();
      bus.entry_req = 1'b0;
      repeat (13) tick();
      chk($sformatf("vec%0d_commits", v), ent_commits - c0, 32'(vecs[v].exp_granted));
      chk($sformatf("vec%0d_denials", v), denials - n0, 32'(!vecs[v].exp_granted));
      chk($sformatf("vec%0d_pending", v), 32'(entry_q.size()), 32'd0);
    end

    // Burst of 6 requests into a depth-4 FIFO
    bus.uni_is_vacated_space = 1'b1;
    bus.free_is_vacated_space = 1'b1;
    c0 = ent_commits;
    d0 = drops;
    rise_q.delete();
    for (int i = 0; i < 6; i++) begin
      bus.entry_req = 1'b1;
      bus.entry_is_uni = 1'(i & 1);
      if (i < 5) entry_q.push_back('{granted: 1'b1, is_uni: 1'(i & 1)});
      tick();
    end
    bus.entry_req = 1'b0;
    chk("t3_level_full", 32'(bus.entry_queue_level), 32'd4);
    waited = 0;
    while (entry_q.size() != 0 && waited < 150) begin
      tick();
      waited++;
    end
    chk("t3_drain_in_time", 32'(entry_q.size()), 32'd0);
    repeat (4) tick();
    chk("t3_commits", ent_commits - c0, 5);
    chk("t3_drops", drops - d0, 1);
    chk("t3_rises", 32'(rise_q.size()), 32'd5);
    min_gap = 1000;
    for (int j = 1; j < rise_q.size(); j++)
      if (rise_q[j] - rise_q[j-1] < min_gap) min_gap = rise_q[j] - rise_q[j-1];
    chk("t3_min_gap_ge_10", 32'(min_gap >= 10), 32'd1);
    chk("t3_level_empty", 32'(bus.entry_queue_level), 32'd0);

    // Exit request while an exit is in progress
    x0 = ext_commits;
    d0 = drops;
    bus.exit_req = 1'b1;
    bus.exit_is_uni = 1'b1;
    exit_q.push_back(1'b1);
    tick();
    bus.exit_req = 1'b0;
    tick();
    tick();
    bus.exit_req = 1'b1;
    bus.exit_is_uni = 1'b0;
    tick();
    bus.exit_req = 1'b0;
    repeat (10) tick();
    chk("t4_exit_commits", ext_commits - x0, 1);
    chk("t4_drops", drops - d0, 1);
    chk("t4_exit_pending", 32'(exit_q.size()), 32'd0);

    // Simultaneous uni entry and free exit
    c0 = ent_commits;
    x0 = ext_commits;
    d0 = drops;
    bus.entry_req = 1'b1;
    bus.entry_is_uni = 1'b1;
    bus.exit_req = 1'b1;
    bus.exit_is_uni = 1'b0;
    entry_q.push_back('{granted: 1'b1, is_uni: 1'b1});
    exit_q.push_back(1'b0);
    tick();
    bus.entry_req = 1'b0;
    bus.exit_req = 1'b0;
    repeat (14) tick();
    chk("t5_entry_commits", ent_commits - c0, 1);
    chk("t5_exit_commits", ext_commits - x0, 1);
    chk("t5_no_drops", drops - d0, 0);

    // Reset in the middle of a strobe with three requests queued
    for (int i = 0; i < 4; i++) begin
      bus.entry_req = 1'b1;
      bus.entry_is_uni = 1'b1;
      entry_q.push_back('{granted: 1'b1, is_uni: 1'b1});
      tick();
    end
    bus.entry_req = 1'b0;
    tick();
    tick();
    chk("t6_in_pulse", 32'(bus.car_entered), 32'd1);
    chk("t6_level_before", 32'(bus.entry_queue_level), 32'd3);
    reset = 1'b1;
    #1;
    chk("t6_reset_outputs", all_outs(), 32'd0);
    entry_q.delete();
    tick();
    tick();
    reset = 1'b0;
    c0 = ent_commits;
    n0 = denials;
    repeat (30) tick();
    chk("t6_no_commit_after", ent_commits - c0, 0);
    chk("t6_no_denial_after", denials - n0, 0);
    chk("t6_outputs_after", all_outs(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
